// File: rtl/ysyx_24080006_mem_arb.sv
// ysyx_24080006_mem_arb: arbitrates between two masters, the IFU and the LSU,
// for a single memory port.
// Only one transaction is in flight at a time. The FSM runs IDLE -> REQ -> RSP -> IDLE.
// Optional feature: define YSYX_24080006_ARB_RR_EN to use round-robin arbitration
// when both masters request in the same cycle. Without it, the LSU always wins a tie.
module ysyx_24080006_mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  input  logic            ifu_rsp_ready,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wstrb,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  state_t          state_reg;
  state_t          state_next;
  logic            owner_reg;
  logic [AW-1:0]   addr_reg;
  logic            wen_reg;
  logic [DW-1:0]   wdata_reg;
  logic [DW/8-1:0] wstrb_reg;

  logic            lsu_wins;
  logic            grant_ifu;
  logic            grant_lsu;
  logic            owner_rsp_ready;

`ifdef YSYX_24080006_ARB_RR_EN
  logic            last_grant_reg;

  // Remember the last winner so that a tie goes to the other master.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_reg <= OWN_IFU;
    end else if (grant_lsu) begin
      last_grant_reg <= OWN_LSU;
    end else if (grant_ifu) begin
      last_grant_reg <= OWN_IFU;
    end
  end

  assign lsu_wins = (last_grant_reg == OWN_IFU);
`else
  assign lsu_wins = 1'b1;
`endif

  // State register, plus capture of the granted request into the memory-side registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_IFU;
      addr_reg  <= '0;
      wen_reg   <= 1'b0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_lsu) begin
        owner_reg <= OWN_LSU;
        addr_reg  <= lsu_addr;
        wen_reg   <= lsu_wen;
        wdata_reg <= lsu_wdata;
        wstrb_reg <= lsu_wstrb;
      end else if (grant_ifu) begin
        // Fetches are always reads, so the write fields are cleared.
        owner_reg <= OWN_IFU;
        addr_reg  <= ifu_addr;
        wen_reg   <= 1'b0;
        wdata_reg <= '0;
        wstrb_reg <= '0;
      end
    end
  end

  // Next-state logic, arbitration, and combinational forwarding of the response to its owner.
  always_comb begin
    state_next      = state_reg;
    grant_ifu       = 1'b0;
    grant_lsu       = 1'b0;
    owner_rsp_ready = 1'b0;
    mem_rsp_ready   = 1'b0;
    ifu_rsp_valid   = 1'b0;
    lsu_rsp_valid   = 1'b0;
    rsp_rdata       = '0;
    rsp_err         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (lsu_req_valid && (!ifu_req_valid || lsu_wins)) begin
          grant_lsu = 1'b1;
        end else if (ifu_req_valid) begin
          grant_ifu = 1'b1;
        end
        if (grant_lsu || grant_ifu) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_next = RSP;
        end
      end
      RSP: begin
        owner_rsp_ready = (owner_reg == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;
        mem_rsp_ready   = owner_rsp_ready;
        ifu_rsp_valid   = mem_rsp_valid && (owner_reg == OWN_IFU);
        lsu_rsp_valid   = mem_rsp_valid && (owner_reg == OWN_LSU);
        rsp_rdata       = mem_rdata;
        rsp_err         = mem_err;
        if (mem_rsp_valid && owner_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // While reset is asserted the FSM sits in IDLE. Mask the grants so a
  // requester never sees ready during that time.
  assign ifu_req_ready = grant_ifu && !reset;
  assign lsu_req_ready = grant_lsu && !reset;

  assign mem_req_valid = (state_reg == REQ);
  assign mem_addr      = addr_reg;
  assign mem_wen       = wen_reg;
  assign mem_wdata     = wdata_reg;
  assign mem_wstrb     = wstrb_reg;

endmodule

// File: tb/tb_ysyx_24080006_mem_arb.sv
// Testbench for ysyx_24080006_mem_arb.
// The directed part follows the test plan.
// The random part is checked against a transaction-level model: an arbitration rule,
// a golden memory updated in grant order, and a slave memory that serves whatever
// request the DUT actually presents.
module tb_ysyx_24080006_mem_arb;

`ifdef YSYX_24080006_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock, reset;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
  logic [31:0] ifu_addr;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_ready, lsu_wen;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_24080006_mem_arb #(.AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_req_valid = 0; ifu_addr = 0; ifu_rsp_ready = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_rsp_ready = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; mem_err = 0;
  endtask

  // A full transaction on one master. The task starts just after a rising edge, with the DUT in IDLE.
  // Setting poke keeps both req_valids high while busy, to show that no second grant is given.
  task automatic do_txn(input bit lsu, input logic [31:0] addr, input bit wen,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int req_wait, input int rsp_stall,
                        input logic [31:0] rdata, input bit err, input bit poke);
    if (lsu) begin
      lsu_req_valid = 1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wstrb = wstrb;
    end else begin
      ifu_req_valid = 1; ifu_addr = addr;
    end
    mem_req_ready = 0;
    @(negedge clock);
    check_eq("grant_ifu", ifu_req_ready, !lsu);
    check_eq("grant_lsu", lsu_req_ready, lsu);
    check_eq("grant_mem_valid", mem_req_valid, 0);
    @(posedge clock); #1;
    ifu_req_valid = poke; lsu_req_valid = poke; mem_req_ready = (req_wait == 0);
    for (int w = 0; w <= req_wait; w++) begin
      @(negedge clock);
      check_eq("req_mem_valid", mem_req_valid, 1);
      check_eq("req_mem_addr", mem_addr, addr);
      check_eq("req_mem_wen", mem_wen, lsu & wen);
      check_eq("req_mem_wstrb", mem_wstrb, lsu ? wstrb : 4'h0);
      if (lsu) check_eq("req_mem_wdata", mem_wdata, wdata);
      check_eq("req_no_grant", {ifu_req_ready, lsu_req_ready}, 0);
      check_eq("req_rsp_quiet", {ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready}, 0);
      @(posedge clock); #1;
      mem_req_ready = (w + 1 == req_wait);
    end
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = rdata; mem_err = err;
    if (lsu) lsu_rsp_ready = (rsp_stall == 0); else ifu_rsp_ready = (rsp_stall == 0);
    for (int s = 0; s <= rsp_stall; s++) begin
      @(negedge clock);
      check_eq("rsp_owner_valid", lsu ? lsu_rsp_valid : ifu_rsp_valid, 1);
      check_eq("rsp_other_valid", lsu ? ifu_rsp_valid : lsu_rsp_valid, 0);
      check_eq("rsp_rdata", rsp_rdata, rdata);
      check_eq("rsp_err", rsp_err, err);
      check_eq("rsp_mem_ready", mem_rsp_ready, s == rsp_stall);
      check_eq("rsp_mem_req_valid", mem_req_valid, 0);
      check_eq("rsp_no_grant", {ifu_req_ready, lsu_req_ready}, 0);
      @(posedge clock); #1;
      if (lsu) lsu_rsp_ready = (s + 1 == rsp_stall); else ifu_rsp_ready = (s + 1 == rsp_stall);
    end
    // Back in IDLE: drive a stray memory response with junk data. It must be ignored.
    ifu_req_valid = 0; lsu_req_valid = 0;
    mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF; mem_err = 1; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    @(negedge clock);
    check_eq("idle_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    check_eq("idle_mem_rsp_ready", mem_rsp_ready, 0);
    check_eq("idle_rsp_rdata", rsp_rdata, 0);
    check_eq("idle_rsp_err", rsp_err, 0);
    check_eq("idle_mem_req_valid", mem_req_valid, 0);
    @(posedge clock); #1;
    clear_inputs();
  endtask

  // State of the model used in the random phase.
  logic [31:0] gold_mem [16];
  logic [31:0] slv_mem [16];
  bit          ifu_pend, lsu_pend, busy, acc, own_lsu, s_pend, last_lsu, exp_l, exp_i, gen, rsp_phase;
  logic [31:0] ifu_a, lsu_a, lsu_d, t_addr, t_wdata, exp_rdata, s_rdata;
  logic        lsu_w, t_wen, exp_err, s_err;
  logic [3:0]  lsu_s, t_wstrb;
  int          s_delay, n_done;

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h8000_0000 + 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 7) == 0) a[12] = 1'b1;
    return a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  initial begin
    clear_inputs();
    reset = 1;
    ifu_req_valid = 1; lsu_req_valid = 1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_ifu_req_ready", ifu_req_ready, 0);
    check_eq("rst_lsu_req_ready", lsu_req_ready, 0);
    check_eq("rst_mem_req_valid", mem_req_valid, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wen", mem_wen, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_mem_wstrb", mem_wstrb, 0);
    check_eq("rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    clear_inputs();
    reset = 0;

    // Both masters request continuously for three back-to-back transactions.
    last_lsu = 0;
    ifu_addr = 32'h8000_0010; lsu_addr = 32'h8000_0020;
    for (int k = 0; k < 3; k++) begin
      ifu_req_valid = 1; lsu_req_valid = 1;
      exp_l = !RR || !last_lsu;
      @(negedge clock);
      check_eq("sim_lsu_grant", lsu_req_ready, exp_l);
      check_eq("sim_ifu_grant", ifu_req_ready, !exp_l);
      last_lsu = exp_l;
      @(posedge clock); #1;
      mem_req_ready = 1;
      @(negedge clock);
      check_eq("sim_mem_addr", mem_addr, exp_l ? 32'h8000_0020 : 32'h8000_0010);
      check_eq("sim_no_grant", {ifu_req_ready, lsu_req_ready}, 0);
      @(posedge clock); #1;
      mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h100 + k; ifu_rsp_ready = 1; lsu_rsp_ready = 1;
      @(negedge clock);
      check_eq("sim_rsp_lsu", lsu_rsp_valid, exp_l);
      check_eq("sim_rsp_ifu", ifu_rsp_valid, !exp_l);
      @(posedge clock); #1;
      mem_rsp_valid = 0; ifu_rsp_ready = 0; lsu_rsp_ready = 0;
      if (k == 2) begin ifu_req_valid = 0; lsu_req_valid = 0; end
    end

    do_txn(0, 32'h8000_0000, 0, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    do_txn(1, 32'h8000_0100, 1, 32'h1234_5678, 4'hF, 0, 0, 32'h0, 0, 0);
    do_txn(0, 32'h8000_0040, 0, 32'h0, 4'h0, 4, 0, 32'h5555_AAAA, 0, 1);
    do_txn(1, 32'h8000_0200, 0, 32'h0, 4'h0, 0, 3, 32'hCAFE_F00D, 1, 0);

    // Assert reset asynchronously while a store is sitting in REQ.
    lsu_req_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 1; lsu_wdata = 32'hA5A5_5A5A; lsu_wstrb = 4'h3;
    @(negedge clock);
    check_eq("ar_grant", lsu_req_ready, 1);
    @(posedge clock); #1;
    lsu_req_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0400;
    @(negedge clock);
    check_eq("ar_pre_mem_valid", mem_req_valid, 1);
    #1 reset = 1;
    #1;
    check_eq("ar_mem_valid", mem_req_valid, 0);
    check_eq("ar_mem_addr", mem_addr, 0);
    check_eq("ar_mem_wen", mem_wen, 0);
    check_eq("ar_mem_wdata", mem_wdata, 0);
    check_eq("ar_mem_wstrb", mem_wstrb, 0);
    check_eq("ar_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
    @(posedge clock); #1;
    reset = 0; ifu_req_valid = 0;
    do_txn(0, 32'h8000_0400, 0, 32'h0, 4'h0, 0, 0, 32'h0BAD_CAFE, 0, 0);

    // Random traffic, starting from a fresh reset.
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 16; i++) begin gold_mem[i] = 0; slv_mem[i] = 0; end
    ifu_pend = 0; lsu_pend = 0; busy = 0; acc = 0; s_pend = 0; last_lsu = 0; n_done = 0;
    ifu_a = 0; lsu_a = 0; lsu_d = 0; lsu_w = 0; lsu_s = 0; own_lsu = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gen = (cyc < 2500);
      if (!gen && !ifu_pend && !lsu_pend && !busy) break;
      if (gen && !ifu_pend && $urandom_range(0, 2) == 0) begin
        ifu_pend = 1; ifu_a = rand_addr();
      end
      if (gen && !lsu_pend && $urandom_range(0, 2) == 0) begin
        lsu_pend = 1; lsu_a = rand_addr(); lsu_w = 1'($urandom_range(0, 1));
        lsu_d = $urandom; lsu_s = 4'($urandom_range(0, 15));
      end
      ifu_req_valid = ifu_pend; ifu_addr = ifu_a;
      lsu_req_valid = lsu_pend; lsu_addr = lsu_a; lsu_wen = lsu_w; lsu_wdata = lsu_d; lsu_wstrb = lsu_s;
      ifu_rsp_ready = 1'($urandom_range(0, 1));
      lsu_rsp_ready = 1'($urandom_range(0, 1));
      mem_req_ready = 1'($urandom_range(0, 1));
      if (s_pend && s_delay == 0) begin
        mem_rsp_valid = 1; mem_rdata = s_rdata; mem_err = s_err;
      end else begin
        if (s_pend) s_delay--;
        mem_rsp_valid = !s_pend && ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom; mem_err = 1'($urandom_range(0, 1));
      end

      @(negedge clock);
      exp_l = 0; exp_i = 0;
      if (!busy) begin
        exp_l = lsu_pend && (!ifu_pend || !RR || !last_lsu);
        exp_i = ifu_pend && !exp_l;
      end
      check_eq("arb_ifu_ready", ifu_req_ready, exp_i);
      check_eq("arb_lsu_ready", lsu_req_ready, exp_l);
      check_eq("mem_req_valid", mem_req_valid, busy && !acc);
      if (busy && !acc && mem_req_valid) begin
        check_eq("mem_addr", mem_addr, t_addr);
        check_eq("mem_wen", mem_wen, t_wen);
        check_eq("mem_wstrb", mem_wstrb, t_wstrb);
        if (t_wen) check_eq("mem_wdata", mem_wdata, t_wdata);
      end
      rsp_phase = busy && acc;
      if (rsp_phase) begin
        check_eq("own_rsp_valid", own_lsu ? lsu_rsp_valid : ifu_rsp_valid, mem_rsp_valid);
        check_eq("other_rsp_valid", own_lsu ? ifu_rsp_valid : lsu_rsp_valid, 0);
        check_eq("fwd_mem_rsp_ready", mem_rsp_ready, own_lsu ? lsu_rsp_ready : ifu_rsp_ready);
        if (mem_rsp_valid && (own_lsu ? lsu_rsp_ready : ifu_rsp_ready)) begin
          check_eq("txn_rdata", rsp_rdata, exp_rdata);
          check_eq("txn_err", rsp_err, exp_err);
          busy = 0; acc = 0; s_pend = 0; n_done++;
        end
      end else begin
        check_eq("quiet_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
        check_eq("quiet_mem_rsp_ready", mem_rsp_ready, 0);
        check_eq("quiet_rsp_rdata", rsp_rdata, 0);
        check_eq("quiet_rsp_err", rsp_err, 0);
      end
      // The slave serves whatever request the DUT actually hands it.
      if (mem_req_valid && mem_req_ready) begin
        if (busy) acc = 1;
        s_err = mem_addr[12];
        s_rdata = 0;
        if (!s_err) begin
          if (mem_wen) slv_mem[mem_addr[5:2]] = merge(slv_mem[mem_addr[5:2]], mem_wdata, mem_wstrb);
          else s_rdata = slv_mem[mem_addr[5:2]];
        end
        s_pend = 1; s_delay = $urandom_range(0, 2);
      end
      // The golden memory is updated in grant order, using what the masters asked for.
      if (exp_l || exp_i) begin
        busy = 1; acc = 0; own_lsu = exp_l; last_lsu = exp_l;
        t_addr = exp_l ? lsu_a : ifu_a;
        t_wen = exp_l & lsu_w;
        t_wdata = lsu_d;
        t_wstrb = exp_l ? lsu_s : 4'h0;
        exp_err = t_addr[12];
        exp_rdata = 0;
        if (!exp_err) begin
          if (t_wen) gold_mem[t_addr[5:2]] = merge(gold_mem[t_addr[5:2]], t_wdata, t_wstrb);
          else exp_rdata = gold_mem[t_addr[5:2]];
        end
      end
      if (ifu_req_ready) ifu_pend = 0;
      if (lsu_req_ready) lsu_pend = 0;
      @(posedge clock); #1;
    end
    check_eq("drain", {ifu_pend, lsu_pend, busy}, 0);
    check_eq("txn_seen", n_done > 100, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
